// File: rtl/mem_burst_pkg.sv
// rtl/mem_burst_pkg.sv - shared state encoding and default widths for the RAM burst master
package mem_burst_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_rd_stage.sv
// rtl/mem_rd_stage.sv - single-entry registered valid/ready output stage for read beats
module mem_rd_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] data,
  input  logic              rd_ready,
  output logic              can_capture,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  // A new word may enter whenever the slot is empty or is being drained this cycle.
  assign can_capture = !rd_valid || rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (capture) begin
      rd_valid <= 1'b1;
      rd_data  <= data;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst command initiator for a single-port RAM with async read
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    remain_q;
  logic                last_cap_q;
  logic                done_q;
  logic                can_capture;
  logic                capture;

  assign cmd_ready    = (state_q == ST_IDLE);
  assign wr_ready     = (state_q == ST_WRITE);
  assign mem_write_en = wr_ready && wr_valid;
  assign mem_addr     = addr_q;
  assign mem_data_in  = wr_data;
  assign done         = done_q;

  // last_cap_q stops further captures while the final beat waits to be consumed.
  assign capture = (state_q == ST_READ) && !last_cap_q && can_capture;

  mem_rd_stage #(.DATA_W(DATA_W)) u_rd_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture     (capture),
    .data        (mem_data_out),
    .rd_ready    (rd_ready),
    .can_capture (can_capture),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      last_cap_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q     <= cmd_addr;
            remain_q   <= cmd_len;
            last_cap_q <= 1'b0;
            state_q    <= cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (wr_valid) begin
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (remain_q == '0) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (capture) begin
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (remain_q == '0) last_cap_q <= 1'b1;
          end else if (last_cap_q && rd_valid && rd_ready) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - randomized self-checking bench with a RAM model and reference memory image
module tb_mem_burst_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       done;
  logic [7:0] mem_addr, mem_data_in, mem_data_out;
  logic       mem_write_en;

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] wq[$];
  int         wr_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  mem_burst_master #(.DATA_W(8), .ADDR_W(8), .LEN_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .done         (done),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out)
  );

  // RAM model: combinational read, write on rising edge
  assign mem_data_out = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_write_en === 1'b1) begin
      ram[mem_addr] <= mem_data_in;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic int ram_diff();
    int bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_len = 8'h05;
    wr_valid = 1'b1; wr_data = 8'h5A; rd_ready = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, wr_ready, rd_valid, done, mem_write_en} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got cmd_ready,wr_ready,rd_valid,done,wen=%b want 10000",
               {cmd_ready, wr_ready, rd_valid, done, mem_write_en});
    end
    n_checks++;
    if (rd_data !== 8'h00 || mem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got rd_data=%h mem_addr=%h want 00 00", rd_data, mem_addr);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_cnt !== 0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_write: got writes=%0d wr_ready=%b want 0 0", wr_cnt, wr_ready);
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // Write burst; data from wq if non-empty else random. gaps: random wr_valid holes.
  // abort_after >= 0: reset asserted once that many beats have been written.
  task automatic do_write(input logic [7:0] a, input int len, input bit gaps,
                          input int abort_after, input string name);
    int beat = 0;
    int cyc = 0;
    int start_cnt;
    logic [7:0] ea = a;
    logic [7:0] d;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len[7:0];
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
    end
    start_cnt = wr_cnt;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_len = 8'($urandom);
    while (beat <= len && cyc < 2000) begin
      if (abort_after >= 0 && beat == abort_after) break;
      wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = (wq.size() > 0) ? wq[0] : 8'($urandom);
      wr_data = d;
      #1;
      n_checks++;
      if (wr_ready !== 1'b1 || cmd_ready !== 1'b0 || mem_write_en !== wr_valid ||
          (wr_valid && (mem_addr !== ea || mem_data_in !== d))) begin
        n_fail++;
        $display("FAIL %s beat%0d: got wr_ready=%b cmd_ready=%b wen=%b addr=%h din=%h want 1 0 %b %h %h",
                 name, beat, wr_ready, cmd_ready, mem_write_en, mem_addr, mem_data_in, wr_valid, ea, d);
      end
      if (wr_valid) begin
        ref_mem[ea] = d;
        ea = ea + 8'd1;
        beat++;
        if (wq.size() > 0) void'(wq.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    if (abort_after >= 0) begin
      wr_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cmd_ready, wr_ready, rd_valid, done, mem_write_en} !== 5'b10000) begin
        n_fail++;
        $display("FAIL %s reset_outputs: got %b want 10000", name,
                 {cmd_ready, wr_ready, rd_valid, done, mem_write_en});
      end
      @(negedge clk);
      wr_valid = 1'b0;
      rst_n = 1'b1;
      n_checks++;
      if (wr_cnt - start_cnt !== abort_after) begin
        n_fail++;
        $display("FAIL %s write_count: got %0d want %0d", name, wr_cnt - start_cnt, abort_after);
      end
    end else begin
      wr_valid = 1'b0;
      n_checks++;
      if (cyc >= 2000) begin
        n_fail++; $display("FAIL %s timeout: got %0d cycles want < 2000", name, cyc);
      end
      n_checks++;
      if (done !== 1'b1 || cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL %s done: got done=%b cmd_ready=%b want 1 1", name, done, cmd_ready);
      end
      n_checks++;
      if (wr_cnt - start_cnt !== len + 1 || (!gaps && cyc !== len + 1)) begin
        n_fail++;
        $display("FAIL %s write_count: got %0d writes in %0d cycles want %0d", name,
                 wr_cnt - start_cnt, cyc, len + 1);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++; $display("FAIL %s done_pulse: got %b want 0", name, done);
      end
    end
    wq.delete();
  endtask

  // mode 0: rd_ready always 1; 1: pattern 1,0,0,1; 2: random
  task automatic do_read(input logic [7:0] a, input int len, input int mode, input string name);
    int cyc = 0;
    int idx = 0;
    int k = 0;
    int first = -1;
    int done_cyc = -1;
    logic rr;
    logic [7:0] ra;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len[7:0];
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_len = 8'($urandom);
    while (cyc < 1000) begin
      cyc++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (rd_valid === 1'b1) begin
        if (first < 0) first = cyc;
        ra = a + idx[7:0];
        n_checks++;
        if (idx > len || rd_data !== ref_mem[ra]) begin
          n_fail++;
          $display("FAIL %s beat%0d: got rd_data=%h want %h (beats=%0d)", name, idx, rd_data,
                   ref_mem[ra], len + 1);
        end
      end
      case (mode)
        0:       rr = 1'b1;
        1:       rr = ((k % 4) == 0) || ((k % 4) == 3);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      k++;
      rd_ready = rr;
      if (rd_valid === 1'b1 && rr) idx++;
      @(negedge clk);
    end
    n_checks++;
    if (done_cyc < 0 || idx !== len + 1) begin
      n_fail++;
      $display("FAIL %s completion: got done_cycle=%0d beats=%0d want beats=%0d", name, done_cyc,
               idx, len + 1);
    end
    n_checks++;
    if (first !== 2) begin
      n_fail++; $display("FAIL %s latency: got first rd_valid at cycle %0d want 2", name, first);
    end
    if (mode == 0) begin
      n_checks++;
      if (done_cyc !== len + 3) begin
        n_fail++; $display("FAIL %s throughput: got done at cycle %0d want %0d", name, done_cyc, len + 3);
      end
    end
    rd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b rd_valid=%b cmd_ready=%b want 0 0 1", name, done,
               rd_valid, cmd_ready);
    end
  endtask

  task automatic check_ram(input string name);
    int bad;
    bad = ram_diff();
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL %s ram_image: got %0d differing words want 0", name, bad);
    end
  endtask

  task automatic test_full_depth();
    do_write(8'h00, 255, 1'b0, -1, "full_depth_write");
    check_ram("full_depth");
  endtask

  task automatic test_write_basic();
    wq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(8'h10, 3, 1'b0, -1, "write_basic");
    n_checks++;
    if (ram[8'h10] !== 8'hA0 || ram[8'h11] !== 8'hA1 || ram[8'h12] !== 8'hA2 || ram[8'h13] !== 8'hA3) begin
      n_fail++;
      $display("FAIL write_basic ram: got %h %h %h %h want a0 a1 a2 a3", ram[8'h10], ram[8'h11],
               ram[8'h12], ram[8'h13]);
    end
  endtask

  task automatic test_read_full();
    do_read(8'h10, 3, 0, "read_full");
  endtask

  task automatic test_read_backpressure();
    do_read(8'h10, 3, 1, "read_bp");
  endtask

  task automatic test_wrap();
    wq = '{8'h11, 8'h22, 8'h33};
    do_write(8'hFE, 2, 1'b0, -1, "write_wrap");
    n_checks++;
    if (ram[8'hFE] !== 8'h11 || ram[8'hFF] !== 8'h22 || ram[8'h00] !== 8'h33) begin
      n_fail++;
      $display("FAIL write_wrap ram: got %h %h %h want 11 22 33", ram[8'hFE], ram[8'hFF], ram[8'h00]);
    end
    do_read(8'hFE, 2, 2, "read_wrap");
  endtask

  task automatic test_write_gaps();
    do_write(8'h80, 7, 1'b1, -1, "write_gaps");
    check_ram("write_gaps");
    do_read(8'h80, 7, 2, "read_gaps");
  endtask

  task automatic test_single_beat();
    do_write(8'h55, 0, 1'b0, -1, "write_len0");
    do_read(8'h55, 0, 0, "read_len0");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    int l;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      l = $urandom_range(0, 20);
      do_write(a, l, 1'b1, -1, "rand_write");
      do_read(a + 8'($urandom_range(0, 3)), l, 2, "rand_read");
    end
    check_ram("back_to_back");
  endtask

  task automatic test_reset_midburst();
    do_write(8'h40, 7, 1'b0, 2, "abort_write");
    check_ram("abort");
    do_read(8'h40, 7, 0, "read_after_abort");
  endtask

  initial begin
    test_reset();
    test_full_depth();
    test_write_basic();
    test_read_full();
    test_read_backpressure();
    test_wrap();
    test_write_gaps();
    test_single_beat();
    test_back_to_back();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
